// File: rtl/src_cmd_loader_if.sv
// Host-side command bus and register-file write bus of the source command loader.
// The master modport is the host/ALU side, and the slave modport is the loader.
interface src_cmd_loader_if #(
    parameter int ADDR_W = 3,
    parameter int CMD_W  = 3,
    parameter int DATA_W = 8
);
    localparam int WORD_W = 2 + ADDR_W + CMD_W + 2 * DATA_W;

    logic              in_valid;
    logic              in_ready;
    logic [CMD_W-1:0]  in_cmd;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_cap;
    logic              flush;
    logic              batch_done;
    logic              w;
    logic [WORD_W-1:0] wdata;
    logic              aluop_st;
    logic [ADDR_W:0]   batch_len;
    logic              busy;

    modport master (
        output in_valid, in_cmd, in_a, in_b, in_cap, flush, batch_done,
        input  in_ready, w, wdata, aluop_st, batch_len, busy
    );

    modport slave (
        input  in_valid, in_cmd, in_a, in_b, in_cap, flush, batch_done,
        output in_ready, w, wdata, aluop_st, batch_len, busy
    );
endinterface

// File: rtl/src_cmd_loader.sv
// Packs host ALU commands into 24-bit source register file entries. It writes one full
// batch of DEPTH entries, pads the unused tail, starts the ALU sweep and waits for it to finish.
module src_cmd_loader #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CMD_W  = 3,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    src_cmd_loader_if.slave     bus
);
    localparam int WORD_W = 2 + ADDR_W + CMD_W + 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] PAD   = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic              w_q,         w_d;
    logic [WORD_W-1:0] wdata_q,     wdata_d;
    logic              aluop_st_q,  aluop_st_d;
    logic [ADDR_W:0]   batch_len_q, batch_len_d;
    logic              busy_q,      busy_d;

    logic              accept;
    logic [ADDR_W-1:0] addr_after;
    logic [ADDR_W:0]   count_after;

    assign bus.in_ready  = (state_q == LOAD) & ~rst;
    assign bus.w         = w_q;
    assign bus.wdata     = wdata_q;
    assign bus.aluop_st  = aluop_st_q;
    assign bus.batch_len = batch_len_q;
    assign bus.busy      = busy_q;

    assign accept      = bus.in_valid & bus.in_ready;
    assign addr_after  = wr_addr_q + ADDR_W'(accept);
    assign count_after = count_q + (ADDR_W + 1)'(accept);

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        count_d     = count_q;
        w_d         = 1'b0;
        wdata_d     = wdata_q;
        aluop_st_d  = 1'b0;
        batch_len_d = batch_len_q;

        case (state_q)
            LOAD: begin
                if (accept) begin
                    w_d       = 1'b1;
                    wdata_d   = {1'b1, bus.in_cap, wr_addr_q, bus.in_cmd, bus.in_a, bus.in_b};
                    count_d   = count_after;
                    // The address sticks at the last entry and returns to 0 only on re-entering LOAD.
                    wr_addr_d = (wr_addr_q == LAST_ADDR) ? wr_addr_q : addr_after;
                end
                if (accept && wr_addr_q == LAST_ADDR) begin
                    state_d = ISSUE;
                end else if (bus.flush && count_after != '0) begin
                    state_d = (addr_after != '0) ? PAD : ISSUE;
                end
            end
            PAD: begin
                w_d     = 1'b1;
                wdata_d = {2'b00, wr_addr_q, {(CMD_W + 2 * DATA_W){1'b0}}};
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = ISSUE;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            ISSUE: begin
                aluop_st_d  = 1'b1;
                batch_len_d = count_q;
                state_d     = WAIT;
            end
            default: begin
                if (bus.batch_done) begin
                    state_d   = LOAD;
                    wr_addr_d = '0;
                    count_d   = '0;
                end
            end
        endcase

        busy_d = (state_d != LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_addr_q   <= '0;
            count_q     <= '0;
            w_q         <= 1'b0;
            wdata_q     <= '0;
            aluop_st_q  <= 1'b0;
            batch_len_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            count_q     <= count_d;
            w_q         <= w_d;
            wdata_q     <= wdata_d;
            aluop_st_q  <= aluop_st_d;
            batch_len_q <= batch_len_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_src_cmd_loader.sv
// Directed bench for src_cmd_loader. Expected writes and batch starts are queued as the
// stimulus is driven and are checked one by one as the loader produces them.
module tb_src_cmd_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    src_cmd_loader_if bus ();

    src_cmd_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int exp_addr   = 0;
    int exp_cnt    = 0;

    logic [23:0] exp_w[$];
    logic [3:0]  exp_len[$];

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Advance one clock and check whatever the loader emitted on that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.w === 1'b1) begin
            if (exp_w.size() == 0) chk("spurious_w", {23'b0, bus.w}, 24'd0);
            else                   chk("wdata", bus.wdata, exp_w.pop_front());
        end
        if (bus.aluop_st === 1'b1) begin
            if (exp_len.size() == 0) chk("spurious_aluop_st", {23'b0, bus.aluop_st}, 24'd0);
            else                     chk("batch_len", {20'b0, bus.batch_len}, {20'b0, exp_len.pop_front()});
        end
    endtask

    task automatic push_pads_and_len();
        for (int k = exp_addr; k < 8; k++) exp_w.push_back({2'b00, 3'(k), 19'b0});
        exp_len.push_back(4'(exp_cnt));
    endtask

    task automatic send(input logic [2:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input logic cap, input bit do_flush, input bit hold);
        bus.in_valid = 1'b1;
        bus.in_cmd   = cmd;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cap   = cap;
        bus.flush    = do_flush;
        exp_w.push_back({1'b1, cap, 3'(exp_addr), cmd, a, b});
        exp_addr++;
        exp_cnt++;
        if (exp_addr == 8)  exp_len.push_back(4'(exp_cnt));
        else if (do_flush)  push_pads_and_len();
        tick();
        if (!hold) bus.in_valid = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic flush_only();
        bus.flush = 1'b1;
        if (exp_cnt > 0) push_pads_and_len();
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (exp_w.size() != 0 || exp_len.size() != 0); k++) tick();
        chk("drain_pending", 24'(exp_w.size() + exp_len.size()), 24'd0);
        tick();
        tick();
    endtask

    task automatic finish_batch(input string tag);
        drain();
        chk({tag, "_busy"},  {23'b0, bus.busy},     24'd1);
        chk({tag, "_ready"}, {23'b0, bus.in_ready}, 24'd0);
        bus.batch_done = 1'b1;
        tick();
        bus.batch_done = 1'b0;
        chk({tag, "_ready_after_done"}, {23'b0, bus.in_ready}, 24'd1);
        exp_addr = 0;
        exp_cnt  = 0;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_cmd     = '0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_cap     = 1'b0;
        bus.flush      = 1'b0;
        bus.batch_done = 1'b0;

        tick();
        tick();
        chk("rst_in_ready", {23'b0, bus.in_ready}, 24'd0);
        rst = 1'b0;
        #1;
        chk("rst_w",         {23'b0, bus.w},        24'd0);
        chk("rst_wdata",     bus.wdata,             24'd0);
        chk("rst_aluop_st",  {23'b0, bus.aluop_st}, 24'd0);
        chk("rst_batch_len", {20'b0, bus.batch_len}, 24'd0);
        chk("rst_busy",      {23'b0, bus.busy},     24'd0);
        chk("idle_in_ready", {23'b0, bus.in_ready}, 24'd1);

        // Full batch of eight back-to-back commands.
        for (int i = 0; i < 8; i++)
            send(3'(i), 8'(i), 8'hF0 | 8'(i), 1'b1, 1'b0, 1'b0);
        finish_batch("full");

        // Partial batch closed by a flush on its own.
        send(3'd5, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
        send(3'd6, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
        send(3'd7, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0);
        flush_only();
        finish_batch("partial");

        // Accept and flush in the same cycle at count 2.
        send(3'd1, 8'hA1, 8'hB1, 1'b1, 1'b0, 1'b0);
        send(3'd2, 8'hA2, 8'hB2, 1'b0, 1'b0, 1'b0);
        send(3'd3, 8'hA3, 8'hB3, 1'b1, 1'b1, 1'b0);
        finish_batch("acc_flush");

        // Flushing an empty batch does nothing.
        flush_only();
        for (int k = 0; k < 4; k++) tick();
        chk("empty_flush_busy",  {23'b0, bus.busy},     24'd0);
        chk("empty_flush_ready", {23'b0, bus.in_ready}, 24'd1);

        // Back-pressure: in_valid stays high through ISSUE and WAIT.
        for (int i = 0; i < 7; i++)
            send(3'(i), 8'h40 + 8'(i), 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
        send(3'd4, 8'hC7, 8'hD7, 1'b1, 1'b0, 1'b1);
        drain();
        chk("bp_ready", {23'b0, bus.in_ready}, 24'd0);
        chk("bp_busy",  {23'b0, bus.busy},     24'd1);
        bus.batch_done = 1'b1;
        tick();
        bus.batch_done = 1'b0;
        chk("bp_ready_after_done", {23'b0, bus.in_ready}, 24'd1);
        exp_addr = 0;
        exp_cnt  = 0;
        exp_w.push_back({1'b1, 1'b1, 3'd0, 3'd4, 8'hC7, 8'hD7});
        exp_addr = 1;
        exp_cnt  = 1;
        tick();
        bus.in_valid = 1'b0;
        chk("bp_first_write_addr0", 24'(exp_w.size()), 24'd0);

        // Spurious batch_done in LOAD with count 4 changes nothing.
        send(3'd1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        send(3'd2, 8'h03, 8'h04, 1'b1, 1'b0, 1'b0);
        send(3'd3, 8'h05, 8'h06, 1'b0, 1'b0, 1'b0);
        bus.batch_done = 1'b1;
        tick();
        bus.batch_done = 1'b0;
        chk("spur_done_busy",  {23'b0, bus.busy},     24'd0);
        chk("spur_done_ready", {23'b0, bus.in_ready}, 24'd1);
        send(3'd7, 8'hEE, 8'hDD, 1'b1, 1'b0, 1'b0);
        flush_only();
        finish_batch("spur_done");

        // Reset in the middle of padding abandons the batch.
        send(3'd2, 8'h9A, 8'hBC, 1'b1, 1'b0, 1'b0);
        send(3'd3, 8'hDE, 8'hF0, 1'b0, 1'b0, 1'b0);
        bus.flush = 1'b1;
        for (int k = 2; k < 5; k++) exp_w.push_back({2'b00, 3'(k), 19'b0});
        tick();
        bus.flush = 1'b0;
        tick();
        tick();
        tick();
        chk("pad_pending", 24'(exp_w.size()), 24'd0);
        rst = 1'b1;
        #1;
        chk("pad_rst_ready", {23'b0, bus.in_ready}, 24'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("pad_rst_w",         {23'b0, bus.w},         24'd0);
        chk("pad_rst_busy",      {23'b0, bus.busy},      24'd0);
        chk("pad_rst_batch_len", {20'b0, bus.batch_len}, 24'd0);
        chk("pad_rst_ready_hi",  {23'b0, bus.in_ready},  24'd1);
        for (int k = 0; k < 6; k++) tick();
        exp_addr = 0;
        exp_cnt  = 0;
        send(3'd6, 8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
        finish_batch("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
